seq_pattern_gen: RTL and testbench

- Bit-serial pattern generator: emits a programmable bit pattern (1..MAX_LEN bits, MSB of the active field first) on a single serial output, one bit per clock.
- Supports a repetition count and an optional idle gap between repetitions.
- Transmit-side counterpart of the team's serial sequence detectors: drives their x input in stimulus and loopback paths, and in-system where a framing pattern must be inserted on a serial line.
- Start/abort control handshake with busy/done/err status.

---
 rtl/seq_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern generator: shifts out pattern[pat_len-1:0], MSB first,
// repeated repeat_cnt times with optional idle gaps, under start/abort control.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; flags err on an illegal pat_len
// SEND  | one pattern bit per cycle, index counting down to 0
// GAP   | idle cycles between repetitions, busy still asserted
module seq_pattern_gen #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [CNT_W-1:0]   repeat_cnt,
  input  logic [GAP_W-1:0]   gap_len,
  input  logic               abort,
  output logic               x,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat_r, pat_n;
  logic [LEN_W-1:0]   len_r, len_n;
  logic [LEN_W-1:0]   idx_r, idx_n;
  logic [CNT_W-1:0]   rep_r, rep_n;
  logic [GAP_W-1:0]   gap_r, gap_n;
  logic [GAP_W-1:0]   gcnt_r, gcnt_n;
  logic               x_n, x_valid_n, busy_n, done_n, err_n;
  logic               start_legal;

  // Shift-based bit pick keeps the index width independent of MAX_LEN.
  function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  assign start_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  // State, latched transfer parameters, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pat_r   <= '0;
      len_r   <= '0;
      idx_r   <= '0;
      rep_r   <= '0;
      gap_r   <= '0;
      gcnt_r  <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      pat_r   <= pat_n;
      len_r   <= len_n;
      idx_r   <= idx_n;
      rep_r   <= rep_n;
      gap_r   <= gap_n;
      gcnt_r  <= gcnt_n;
      x       <= x_n;
      x_valid <= x_valid_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they register cleanly.
  always_comb begin
    state_n   = state;
    pat_n     = pat_r;
    len_n     = len_r;
    idx_n     = idx_r;
    rep_n     = rep_r;
    gap_n     = gap_r;
    gcnt_n    = gcnt_r;
    x_n       = 1'b0;
    x_valid_n = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_legal) begin
            state_n   = S_SEND;
            pat_n     = pattern;
            len_n     = pat_len;
            idx_n     = pat_len - LEN_W'(1);
            rep_n     = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            gap_n     = gap_len;
            x_n       = bit_at(pattern, pat_len - LEN_W'(1));
            x_valid_n = 1'b1;
            busy_n    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (idx_r == '0) begin
          if (rep_r == CNT_W'(1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            rep_n = rep_r - CNT_W'(1);
            if (gap_r != '0) begin
              state_n = S_GAP;
              gcnt_n  = gap_r;
              busy_n  = 1'b1;
            end else begin
              idx_n     = len_r - LEN_W'(1);
              x_n       = bit_at(pat_r, len_r - LEN_W'(1));
              x_valid_n = 1'b1;
              busy_n    = 1'b1;
            end
          end
        end else begin
          idx_n     = idx_r - LEN_W'(1);
          x_n       = bit_at(pat_r, idx_r - LEN_W'(1));
          x_valid_n = 1'b1;
          busy_n    = 1'b1;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (gcnt_r == GAP_W'(1)) begin
          state_n   = S_SEND;
          idx_n     = len_r - LEN_W'(1);
          x_n       = bit_at(pat_r, len_r - LEN_W'(1));
          x_valid_n = 1'b1;
          busy_n    = 1'b1;
        end else begin
          gcnt_n = gcnt_r - GAP_W'(1);
          busy_n = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: directed table of transfers, randomized
// transfers, and hand-written reset/abort corner cases, all checked against
// a per-cycle expected-output queue built from the transfer parameters.
module tb_seq_pattern_gen;

  logic        clk, rst_n, start, abort;
  logic [15:0] pattern;
  logic [4:0]  pat_len;
  logic [7:0]  repeat_cnt;
  logic [3:0]  gap_len;
  logic        x, x_valid, busy, done, err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic x;
    logic xv;
    logic busy;
    logic done;
    logic err;
  } obs_t;

  typedef struct {
    logic [15:0] pattern;
    int          len;
    int          rep;
    int          gap;
    int          abort_at;
    bit          abort_w_start;
    int          exp_done;
    bit          exp_err;
  } vec_t;

  obs_t exp_q[$];
  vec_t vecs[9];

  seq_pattern_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic obs_t sample();
    obs_t o;
    o.x = x; o.xv = x_valid; o.busy = busy; o.done = done; o.err = err;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t req, input int cyc);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d x/xv/busy/done/err got=%b required=%b", name, cyc, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Expected output stream, one entry per cycle after the start edge.
  function automatic void build_model(input logic [15:0] p, input int len, input int rep,
                                      input int gap, input int abort_at);
    obs_t o;
    int reps;
    exp_q.delete();
    if (len < 1 || len > 16) begin
      o = '0; o.err = 1'b1; exp_q.push_back(o);
      o = '0; exp_q.push_back(o);
      return;
    end
    reps = (rep < 1) ? 1 : rep;
    for (int r = 0; r < reps; r++) begin
      for (int b = len - 1; b >= 0; b--) begin
        o = '0; o.x = p[b]; o.xv = 1'b1; o.busy = 1'b1;
        exp_q.push_back(o);
      end
      if (r < reps - 1)
        for (int g = 0; g < gap; g++) begin
          o = '0; o.busy = 1'b1;
          exp_q.push_back(o);
        end
    end
    if (abort_at >= 0 && abort_at < exp_q.size()) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      o = '0;
    end else begin
      o = '0; o.done = 1'b1;
    end
    exp_q.push_back(o);
  endfunction

  // Issues start in the current cycle, then checks every cycle of the transfer.
  // While busy, the inputs are scrambled (including stray starts) to show they are ignored.
  task automatic run_xfer(input logic [15:0] p, input int len, input int rep, input int gap,
                          input int abort_at, input bit abort_w_start,
                          output int done_cyc, output bit err_seen);
    obs_t got;
    build_model(p, len, rep, gap, abort_at);
    start = 1'b1; pattern = p; pat_len = len[4:0];
    repeat_cnt = rep[7:0]; gap_len = gap[3:0]; abort = abort_w_start;
    done_cyc = 0; err_seen = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      got = sample();
      if (i == 0) err_seen = got.err;
      if (got.done && done_cyc == 0) done_cyc = i + 1;
      check("xfer", got, exp_q[i], i + 1);
      if (exp_q[i].busy) begin
        start = ($urandom_range(0, 3) == 0);
        abort = (i == abort_at);
        pattern = 16'($urandom);
        pat_len = 5'($urandom_range(0, 31));
        repeat_cnt = 8'($urandom);
        gap_len = 4'($urandom);
      end else begin
        start = 1'b0;
        abort = 1'b0;
      end
    end
  endtask

  initial begin
    int   dc;
    bit   es;
    obs_t zero, req;
    int   len, rep, gap, reps, nbusy, ab;

    vecs[0] = '{16'h0005,  3, 1,  0, -1, 1'b0,  4, 1'b0};
    vecs[1] = '{16'h0005,  3, 2,  2, -1, 1'b0,  9, 1'b0};
    vecs[2] = '{16'hA5C3, 16, 0,  0, -1, 1'b0, 17, 1'b0};
    vecs[3] = '{16'h0005,  0, 1,  0, -1, 1'b0,  0, 1'b1};
    vecs[4] = '{16'h0005, 17, 1,  0, -1, 1'b0,  0, 1'b1};
    vecs[5] = '{16'h000B,  4, 3,  1,  1, 1'b0,  0, 1'b0};
    vecs[6] = '{16'h0001,  1, 3,  0, -1, 1'b1,  4, 1'b0};
    vecs[7] = '{16'h0002,  2, 2, 15, -1, 1'b0, 20, 1'b0};
    vecs[8] = '{16'h000B,  4, 3,  1, 13, 1'b0,  0, 1'b0};

    zero = '0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; pat_len = '0; repeat_cnt = '0; gap_len = '0;
    #12;
    check("reset_state", sample(), zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", sample(), zero, 0);

    foreach (vecs[k]) begin
      run_xfer(vecs[k].pattern, vecs[k].len, vecs[k].rep, vecs[k].gap,
               vecs[k].abort_at, vecs[k].abort_w_start, dc, es);
      check_int($sformatf("done_cycle_vec%0d", k), dc, vecs[k].exp_done);
      check_int($sformatf("err_vec%0d", k), int'(es), int'(vecs[k].exp_err));
    end

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 20);
      rep = $urandom_range(0, 4);
      gap = $urandom_range(0, 3);
      ab  = -1;
      if (len >= 1 && len <= 16 && $urandom_range(0, 3) == 0) begin
        reps  = (rep < 1) ? 1 : rep;
        nbusy = reps * len + (reps - 1) * gap;
        ab    = $urandom_range(0, nbusy - 1);
      end
      run_xfer(16'($urandom), len, rep, gap, ab, 1'($urandom_range(0, 1)), dc, es);
    end

    // Reset in the middle of a gap: outputs clear without a clock edge.
    start = 1'b1; pattern = 16'h0005; pat_len = 5'd3; repeat_cnt = 8'd2; gap_len = 4'd4; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    req = '0; req.busy = 1'b1;
    check("mid_gap", sample(), req, 5);
    #2 rst_n = 1'b0;
    #1 check("async_reset", sample(), zero, 0);
    @(posedge clk); #1;
    check("held_reset", sample(), zero, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_after_mid_reset", sample(), zero, i);
    end

    run_xfer(16'h0005, 3, 1, 0, -1, 1'b0, dc, es);
    check_int("done_cycle_after_reset", dc, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
